mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000, is the byte address of data-memory word 0.
REQ-002 Parameter DEPTH, default 64, is the number of 32-bit data-memory words (power of two).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  EX stage presents a request.
REQ-006 in_ready  output  1  stage accepts the request this cycle.
REQ-007 memRead  input  1  request is a load.
REQ-008 memWrite  input  1  request is a store.
REQ-009 memtoReg_in  input  1  writeback select, passed through.
REQ-010 regWrite_in  input  1  register-write enable, passed through.
REQ-011 rd_in  input  5  destination register, passed through.
REQ-012 ALUresult_in  input  32  ALU result; also the byte address for loads and stores.
REQ-013 writeData  input  32  store data.
REQ-014 out_valid  output  1  result is held for the WB stage.
REQ-015 out_ready  input  1  WB stage consumes the result this cycle.
REQ-016 memtoReg  output  1  registered copy of memtoReg_in; drives the writeback mux select.
REQ-017 regWrite  output  1  registered regWrite_in, forced to 0 on error.
REQ-018 rd  output  5  registered rd_in.
REQ-019 ALUresult  output  32  registered ALUresult_in.
REQ-020 DMresult  output  32  load data; 0 for non-loads and errors.
REQ-021 err  output  1  the held result is a faulted access.

Function
REQ-022 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-023 Accept occurs when in_valid && in_ready at a rising edge; on accept all output registers load and out_valid becomes 1.
REQ-024 When out_valid && !out_ready, every output SHALL hold stable and no new request is accepted.
REQ-025 When out_ready is high and no accept occurs, out_valid SHALL clear at the edge.
REQ-026 Latency SHALL be one cycle from accept to out_valid, including load data, with zero bubbles at full throughput.
REQ-027 Word index = (ALUresult_in - BASE_ADDR) >> 2; the address is in range iff ALUresult_in >= BASE_ADDR and index < DEPTH.
REQ-028 A memory access faults if it is out of range, if ALUresult_in[1:0] != 0, or if memRead && memWrite are both set.
REQ-029 A valid store SHALL write writeData to the memory word at the accept edge; a faulted store writes nothing.
REQ-030 A valid load SHALL return the word read at the accept edge in DMresult, including data written by a store accepted in an earlier cycle.
REQ-031 On fault: err=1, regWrite=0, DMresult=0, with memtoReg, rd and ALUresult still passed through.
REQ-032 A request with neither memRead nor memWrite SHALL produce DMresult=0 and err=0, and touches no memory.
REQ-033 FSM states: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY->FULL on accept.
- FULL->FULL on accept, or on hold (!out_ready).
- FULL->EMPTY when out_ready && !in_valid.

Reset
REQ-034 While rst_n=0: out_valid=0, err=0, memtoReg=0, regWrite=0, rd=0, ALUresult=0, DMresult=0, FSM in EMPTY, and in_ready=1.
REQ-035 Reset asserted mid-hold SHALL discard the held result; memory contents are not reset and are retained.
REQ-036 The first accept MAY occur on the first rising edge after rst_n deasserts.

Structure
REQ-037 Shared package mips_mem_pkg SHALL hold BASE_ADDR, DEPTH, the index width clog2(DEPTH), and the state encoding.
REQ-038 One sub-module, dmem_ram, SHALL implement the synchronous single-port RAM (write-enable, index, wdata, registered rdata).

Verification
REQ-039 Store 32'h00000001 @32'h10010004, then load @32'h10010004 with memtoReg_in=1 -> DMresult=1, ALUresult=32'h10010004, memtoReg=1, err=0.
REQ-040 Back-to-back stores of the Fibonacci values 1,2,3,5,8,13,21,34,55,89,144 to 32'h10010004..32'h1001002C with out_ready=1, then 11 loads -> one result per cycle, values in order, no bubbles.
REQ-041 R-type pass-through with memtoReg_in=0, ALUresult_in=32'h00FF, rd_in=5'd3 -> ALUresult=32'h00FF, DMresult=0, regWrite=1, rd=3.
REQ-042 Load @32'h10010006 and load @32'h10010100 (DEPTH=64) -> each returns err=1, regWrite=0, DMresult=0, and memory is unchanged.
REQ-043 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; on release, the pending request is accepted on the next edge.
REQ-044 Assert rst_n=0 asynchronously during a hold -> out_valid drops immediately; a later load of 32'h10010004 still returns 1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared data-memory geometry and MEM stage state encoding
package mips_mem_pkg;
  localparam logic [31:0] DM_BASE = 32'h10010000;
  localparam int DM_DEPTH = 64;
  localparam int DM_IDX_W = $clog2(DM_DEPTH);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL = 1'b1;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: synchronous single-port data RAM with registered read data
module dmem_ram import mips_mem_pkg::*; #(
  parameter int DEPTH = DM_DEPTH,
  parameter int AW = DM_IDX_W
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:DEPTH-1];
  // read data only changes on an enabled access, so it holds while the stage stalls
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM pipeline stage with valid/ready handshake and fault detection
module mem_access_stage import mips_mem_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = DM_BASE,
  parameter int DEPTH = DM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memtoReg_in,
  input  logic        regWrite_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] writeData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        memtoReg,
  output logic        regWrite,
  output logic [4:0]  rd,
  output logic [31:0] ALUresult,
  output logic [31:0] DMresult,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  logic        state, accept, in_range, fault, ld_q;
  logic [31:2] off;
  logic [31:0] rdata;
  assign out_valid = (state == FULL);
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign off = ALUresult_in[31:2] - BASE_ADDR[31:2];
  assign in_range = (ALUresult_in >= BASE_ADDR) && ({2'b00, off} < 32'(DEPTH));
  assign fault = (memRead || memWrite) &&
                 (!in_range || ALUresult_in[1:0] != 2'b00 || (memRead && memWrite));
  assign DMresult = ld_q ? rdata : '0;
  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (accept && memWrite && !fault),
    .idx   (off[AW+1:2]),
    .wdata (writeData),
    .rdata (rdata)
  );
  // result register: load on accept, drain when WB consumes with nothing new arriving
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      memtoReg <= 1'b0;
      regWrite <= 1'b0;
      rd <= '0;
      ALUresult <= '0;
      err <= 1'b0;
      ld_q <= 1'b0;
    end else if (accept) begin
      state <= FULL;
      memtoReg <= memtoReg_in;
      regWrite <= regWrite_in && !fault;
      rd <= rd_in;
      ALUresult <= ALUresult_in;
      err <= fault;
      ld_q <= memRead && !fault;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed tests with a behavioural scoreboard for the MEM stage
module tb_mem_access_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, memRead = 1'b0, memWrite = 1'b0;
  logic        memtoReg_in = 1'b0, regWrite_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic [31:0] ALUresult_in = '0, writeData = '0;
  logic        out_valid, out_ready = 1'b1, memtoReg, regWrite, err;
  logic [4:0]  rd;
  logic [31:0] ALUresult, DMresult;
  int total = 0, bad = 0, cyc = 0;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .memRead(memRead), .memWrite(memWrite), .memtoReg_in(memtoReg_in),
    .regWrite_in(regWrite_in), .rd_in(rd_in), .ALUresult_in(ALUresult_in),
    .writeData(writeData), .out_valid(out_valid), .out_ready(out_ready),
    .memtoReg(memtoReg), .regWrite(regWrite), .rd(rd), .ALUresult(ALUresult),
    .DMresult(DMresult), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: a word array and the expected content of the output slot
  logic [31:0] mem_m [0:63];
  logic        m_valid = 1'b0, m_m2r, m_rw, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_dm;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_valid = 1'b0;
    else if (in_valid && (!m_valid || out_ready)) begin
      automatic longint a = longint'(ALUresult_in);
      automatic longint w = (a - 64'h10010000) / 4;
      automatic bit ok = a >= 64'h10010000 && w < 64 && a % 4 == 0 && !(memRead && memWrite);
      automatic bit f = (memRead || memWrite) && !ok;
      m_valid = 1'b1;
      m_m2r = memtoReg_in;
      m_rw = regWrite_in && !f;
      m_rd = rd_in;
      m_alu = ALUresult_in;
      m_err = f;
      m_dm = (memRead && !f) ? mem_m[int'(w)] : 32'h0;
      if (memWrite && !f) mem_m[int'(w)] = writeData;
    end else if (out_ready) m_valid = 1'b0;
  end

  // compare process: every cycle, away from the clock edge
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("sb.out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("sb.in_ready", {31'b0, in_ready}, {31'b0, !m_valid || out_ready});
      if (m_valid) begin
        chk("sb.memtoReg", {31'b0, memtoReg}, {31'b0, m_m2r});
        chk("sb.regWrite", {31'b0, regWrite}, {31'b0, m_rw});
        chk("sb.rd", {27'b0, rd}, {27'b0, m_rd});
        chk("sb.ALUresult", ALUresult, m_alu);
        chk("sb.DMresult", DMresult, m_dm);
        chk("sb.err", {31'b0, err}, {31'b0, m_err});
      end
    end
  end

  task automatic send(input logic mr, mw, m2r, rw, input logic [4:0] r,
                      input logic [31:0] a, wd);
    bit got = 0;
    in_valid = 1'b1; memRead = mr; memWrite = mw; memtoReg_in = m2r;
    regWrite_in = rw; rd_in = r; ALUresult_in = a; writeData = wd;
    for (int n = 0; n < 50 && !got; n++) begin
      #1 got = in_ready;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout actual=no_accept required=accept addr=%h", a);
    end
  endtask

  task automatic store(input logic [31:0] a, wd);
    send(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, a, wd);
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] r);
    send(1'b1, 1'b0, 1'b1, 1'b1, r, a, 32'h0);
  endtask

  initial begin
    automatic logic [31:0] fib [11] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
    int c0;
    foreach (mem_m[i]) mem_m[i] = 32'h0;
    @(negedge clk);
    chk("rst.out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst.err", {31'b0, err}, 32'h0);
    chk("rst.regWrite", {31'b0, regWrite}, 32'h0);
    chk("rst.memtoReg", {31'b0, memtoReg}, 32'h0);
    chk("rst.rd", {27'b0, rd}, 32'h0);
    chk("rst.ALUresult", ALUresult, 32'h0);
    chk("rst.DMresult", DMresult, 32'h0);
    rst_n = 1'b1;
    // store then load the same word
    store(32'h10010004, 32'h1);
    load(32'h10010004, 5'd8);
    chk("ld1.DMresult", DMresult, 32'h1);
    chk("ld1.ALUresult", ALUresult, 32'h10010004);
    chk("ld1.memtoReg", {31'b0, memtoReg}, 32'h1);
    chk("ld1.err", {31'b0, err}, 32'h0);
    // back-to-back Fibonacci stores and loads
    for (int i = 0; i < 11; i++) store(32'h10010004 + 32'(4 * i), fib[i]);
    c0 = cyc;
    for (int i = 0; i < 11; i++) begin
      load(32'h10010004 + 32'(4 * i), 5'(i + 1));
      chk("fib.DMresult", DMresult, fib[i]);
      chk("fib.out_valid", {31'b0, out_valid}, 32'h1);
    end
    chk("fib.cycles", 32'(cyc - c0), 32'd11);
    // R-type pass-through
    send(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h000000FF, 32'h0);
    chk("rtype.ALUresult", ALUresult, 32'h000000FF);
    chk("rtype.DMresult", DMresult, 32'h0);
    chk("rtype.regWrite", {31'b0, regWrite}, 32'h1);
    chk("rtype.rd", {27'b0, rd}, 32'd3);
    chk("rtype.err", {31'b0, err}, 32'h0);
    // faults: misaligned, out of range, and stores that must not land
    load(32'h10010006, 5'd4);
    chk("mis.err", {31'b0, err}, 32'h1);
    chk("mis.regWrite", {31'b0, regWrite}, 32'h0);
    chk("mis.DMresult", DMresult, 32'h0);
    load(32'h10010100, 5'd5);
    chk("oor.err", {31'b0, err}, 32'h1);
    chk("oor.regWrite", {31'b0, regWrite}, 32'h0);
    chk("oor.DMresult", DMresult, 32'h0);
    chk("oor.rd", {27'b0, rd}, 32'd5);
    store(32'h10010006, 32'hDEADBEEF);
    send(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h10010008, 32'h0BADF00D);
    chk("both.err", {31'b0, err}, 32'h1);
    load(32'h10010004, 5'd7);
    chk("keep4.DMresult", DMresult, 32'h1);
    load(32'h10010008, 5'd7);
    chk("keep8.DMresult", DMresult, 32'h2);
    // backpressure hold for three cycles
    send(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h000000AA, 32'h0);
    out_ready = 1'b0;
    in_valid = 1'b1; memRead = 1'b0; memWrite = 1'b0; regWrite_in = 1'b1;
    rd_in = 5'd2; ALUresult_in = 32'h000000BB;
    repeat (3) begin
      @(posedge clk); @(negedge clk); #1;
      chk("hold.in_ready", {31'b0, in_ready}, 32'h0);
      chk("hold.ALUresult", ALUresult, 32'h000000AA);
      chk("hold.rd", {27'b0, rd}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("rel.ALUresult", ALUresult, 32'h000000BB);
    chk("rel.rd", {27'b0, rd}, 32'd2);
    in_valid = 1'b0;
    @(negedge clk);
    // asynchronous reset in the middle of a hold
    load(32'h10010008, 5'd9);
    out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst.in_ready", {31'b0, in_ready}, 32'h1);
    chk("arst.DMresult", DMresult, 32'h0);
    chk("arst.ALUresult", ALUresult, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    load(32'h10010004, 5'd10);
    chk("post.DMresult", DMresult, 32'h1);
    chk("post.err", {31'b0, err}, 32'h0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
